// File: rtl/switch_debouncer.sv
// Multi-channel push-button conditioner: a 2-flop synchroniser per channel,
// an integrating debounce counter, and a per-channel repeat FSM. Each
// channel produces a debounced level, one-clock press/release pulses, and
// optional timed auto-repeat press pulses while the switch is held.
module switch_debouncer #(
    parameter int NUM_SW          = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_RATE     = 2500000
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Switch,
    output logic [NUM_SW-1:0] o_Press,
    output logic [NUM_SW-1:0] o_Release
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } rep_state_t;

    logic [NUM_SW-1:0] sync1;
    logic [NUM_SW-1:0] sync2;
    logic [DEB_W-1:0]  deb_cnt [NUM_SW];
    logic [NUM_SW-1:0] rise;
    logic [NUM_SW-1:0] fall;

    rep_state_t        state      [NUM_SW];
    rep_state_t        state_next [NUM_SW];
    logic [REP_W-1:0]  rep_cnt      [NUM_SW];
    logic [REP_W-1:0]  rep_cnt_next [NUM_SW];
    logic [NUM_SW-1:0] press_next;
    logic [NUM_SW-1:0] release_next;

    // Two-flop synchroniser bringing the raw switches into the clock domain.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1 <= {NUM_SW{1'b0}};
            sync2 <= {NUM_SW{1'b0}};
        end else begin
            sync1 <= i_Switch;
            sync2 <= sync1;
        end
    end

    // Accepted level changes: the synchronised sample has disagreed with the
    // current level long enough, so the level flips on this edge.
    always_comb begin
        rise = {NUM_SW{1'b0}};
        fall = {NUM_SW{1'b0}};
        for (int i = 0; i < NUM_SW; i++) begin
            if ((sync2[i] != o_Switch[i]) && (deb_cnt[i] == DEB_LAST)) begin
                rise[i] = sync2[i];
                fall[i] = ~sync2[i];
            end else begin
                rise[i] = 1'b0;
                fall[i] = 1'b0;
            end
        end
    end

    // Integrating debounce counter and debounced level per channel.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < NUM_SW; i++) begin
                deb_cnt[i] <= {DEB_W{1'b0}};
            end
            o_Switch <= {NUM_SW{1'b0}};
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                if (sync2[i] == o_Switch[i]) begin
                    deb_cnt[i] <= {DEB_W{1'b0}};
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb_cnt[i]  <= {DEB_W{1'b0}};
                    o_Switch[i] <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // Repeat FSM next-state and pulse decode; a release always wins over a
    // repeat pulse due on the same edge.
    always_comb begin
        press_next   = {NUM_SW{1'b0}};
        release_next = {NUM_SW{1'b0}};
        for (int i = 0; i < NUM_SW; i++) begin
            state_next[i]   = state[i];
            rep_cnt_next[i] = rep_cnt[i];
            case (state[i])
                RELEASED: begin
                    if (rise[i]) begin
                        press_next[i]   = 1'b1;
                        rep_cnt_next[i] = {REP_W{1'b0}};
                        state_next[i]   = HELD_DELAY;
                    end else begin
                        rep_cnt_next[i] = {REP_W{1'b0}};
                    end
                end
                HELD_DELAY: begin
                    if (fall[i]) begin
                        release_next[i] = 1'b1;
                        rep_cnt_next[i] = {REP_W{1'b0}};
                        state_next[i]   = RELEASED;
                    end else if (rep_cnt[i] == DELAY_LAST) begin
                        if (REPEAT_EN != 0) begin
                            press_next[i]   = 1'b1;
                            rep_cnt_next[i] = {REP_W{1'b0}};
                            state_next[i]   = HELD_REPEAT;
                        end else begin
                            rep_cnt_next[i] = rep_cnt[i];
                        end
                    end else begin
                        rep_cnt_next[i] = rep_cnt[i] + REP_W'(1);
                    end
                end
                HELD_REPEAT: begin
                    if (fall[i]) begin
                        release_next[i] = 1'b1;
                        rep_cnt_next[i] = {REP_W{1'b0}};
                        state_next[i]   = RELEASED;
                    end else if (rep_cnt[i] == RATE_LAST) begin
                        press_next[i]   = 1'b1;
                        rep_cnt_next[i] = {REP_W{1'b0}};
                    end else begin
                        rep_cnt_next[i] = rep_cnt[i] + REP_W'(1);
                    end
                end
                default: begin
                    rep_cnt_next[i] = {REP_W{1'b0}};
                    state_next[i]   = RELEASED;
                end
            endcase
        end
    end

    // Repeat FSM state, repeat counters and registered pulse outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int i = 0; i < NUM_SW; i++) begin
                state[i]   <= RELEASED;
                rep_cnt[i] <= {REP_W{1'b0}};
            end
            o_Press   <= {NUM_SW{1'b0}};
            o_Release <= {NUM_SW{1'b0}};
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                state[i]   <= state_next[i];
                rep_cnt[i] <= rep_cnt_next[i];
            end
            o_Press   <= press_next;
            o_Release <= release_next;
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3: one instance with auto-repeat, one without.
module tb_switch_debouncer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] sw    = 4'b0000;
    logic [3:0] sw_nr = 4'b0000;
    logic [3:0] lvl, pr, rl;
    logic [3:0] nr_lvl, nr_pr, nr_rl;
    int total = 0;
    int bad   = 0;
    logic [4:0] bounce;

    always #5 clk = ~clk;

    switch_debouncer #(
        .NUM_SW(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Switch(sw),
        .o_Switch(lvl), .o_Press(pr), .o_Release(rl)
    );

    switch_debouncer #(
        .NUM_SW(4), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
        .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) dut_nr (
        .i_Clk(clk), .i_Rst(rst), .i_Switch(sw_nr),
        .o_Switch(nr_lvl), .o_Press(nr_pr), .o_Release(nr_rl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One clock, then compare {level, press, release} of the repeat instance.
    task automatic tick_chk(input string tag, input logic [3:0] el, input logic [3:0] ep,
                            input logic [3:0] er);
        tick();
        check(tag, {20'd0, lvl, pr, rl}, {20'd0, el, ep, er});
    endtask

    // One clock, then compare {level, press, release} of the no-repeat instance.
    task automatic tick_nr(input string tag, input logic [3:0] el, input logic [3:0] ep,
                           input logic [3:0] er);
        tick();
        check(tag, {20'd0, nr_lvl, nr_pr, nr_rl}, {20'd0, el, ep, er});
    endtask

    initial begin
        // Reset state
        tick(); tick();
        tick_chk("reset", 4'b0000, 4'b0000, 4'b0000);
        check("reset_nr", {20'd0, nr_lvl, nr_pr, nr_rl}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick_chk("idle", 4'b0000, 4'b0000, 4'b0000);

        // 1. Clean press on ch0, then release before any repeat
        sw = 4'b0001;
        for (int k = 0; k < 5; k++) tick_chk($sformatf("t1_wait%0d", k), 4'b0000, 4'b0000, 4'b0000);
        tick_chk("t1_accept", 4'b0001, 4'b0001, 4'b0000);
        tick_chk("t1_after", 4'b0001, 4'b0000, 4'b0000);
        sw = 4'b0000;
        for (int k = 0; k < 5; k++) tick_chk($sformatf("t1_hold%0d", k), 4'b0001, 4'b0000, 4'b0000);
        tick_chk("t1_release", 4'b0000, 4'b0000, 4'b0001);
        tick_chk("t1_idle", 4'b0000, 4'b0000, 4'b0000);

        // 2. Bounce rejection on ch1: 1,0,1,1,0 then 3-clock pulse
        bounce = 5'b01101;
        for (int k = 0; k < 5; k++) begin
            sw[1] = bounce[k];
            tick_chk($sformatf("t2_bounce%0d", k), 4'b0000, 4'b0000, 4'b0000);
        end
        sw[1] = 1'b0;
        for (int k = 0; k < 8; k++) tick_chk($sformatf("t2_quiet%0d", k), 4'b0000, 4'b0000, 4'b0000);
        sw[1] = 1'b1;
        for (int k = 0; k < 3; k++) tick_chk($sformatf("t2_short%0d", k), 4'b0000, 4'b0000, 4'b0000);
        sw[1] = 1'b0;
        for (int k = 0; k < 8; k++) tick_chk($sformatf("t2_after%0d", k), 4'b0000, 4'b0000, 4'b0000);

        // 3. Auto-repeat on ch2; release lands on a due repeat edge (A+37)
        sw = 4'b0100;
        for (int k = 0; k < 5; k++) tick_chk($sformatf("t3_wait%0d", k), 4'b0000, 4'b0000, 4'b0000);
        tick_chk("t3_accept", 4'b0100, 4'b0100, 4'b0000);
        for (int k = 1; k <= 36; k++) begin
            tick_chk($sformatf("t3_hold%0d", k), 4'b0100,
                     ((k == 10) || (k > 10 && ((k - 10) % 3) == 0)) ? 4'b0100 : 4'b0000,
                     4'b0000);
            if (k == 31) sw = 4'b0000;
        end
        tick_chk("t3_release", 4'b0000, 4'b0000, 4'b0100);
        for (int k = 0; k < 6; k++) tick_chk($sformatf("t3_idle%0d", k), 4'b0000, 4'b0000, 4'b0000);

        // 4. Simultaneous channels
        sw = 4'b1111;
        for (int k = 0; k < 5; k++) tick_chk($sformatf("t4_wait%0d", k), 4'b0000, 4'b0000, 4'b0000);
        tick_chk("t4_accept", 4'b1111, 4'b1111, 4'b0000);
        tick_chk("t4_a1", 4'b1111, 4'b0000, 4'b0000);
        sw = 4'b0111;
        for (int k = 2; k <= 6; k++) tick_chk($sformatf("t4_a%0d", k), 4'b1111, 4'b0000, 4'b0000);
        tick_chk("t4_rel3", 4'b0111, 4'b0000, 4'b1000);
        tick_chk("t4_a8", 4'b0111, 4'b0000, 4'b0000);
        sw = 4'b0000;
        tick_chk("t4_a9", 4'b0111, 4'b0000, 4'b0000);
        tick_chk("t4_rep10", 4'b0111, 4'b0111, 4'b0000);
        tick_chk("t4_a11", 4'b0111, 4'b0000, 4'b0000);
        tick_chk("t4_a12", 4'b0111, 4'b0000, 4'b0000);
        tick_chk("t4_rep13", 4'b0111, 4'b0111, 4'b0000);
        tick_chk("t4_relall", 4'b0000, 4'b0000, 4'b0111);
        tick_chk("t4_idle", 4'b0000, 4'b0000, 4'b0000);

        // 5. Reset mid-hold on ch0, after its first repeat
        sw = 4'b0001;
        for (int k = 0; k < 5; k++) tick_chk($sformatf("t5_wait%0d", k), 4'b0000, 4'b0000, 4'b0000);
        tick_chk("t5_accept", 4'b0001, 4'b0001, 4'b0000);
        for (int k = 1; k <= 11; k++)
            tick_chk($sformatf("t5_hold%0d", k), 4'b0001, (k == 10) ? 4'b0001 : 4'b0000, 4'b0000);
        #3 rst = 1'b1;
        #1 check("t5_async", {20'd0, lvl, pr, rl}, 32'd0);
        tick_chk("t5_inrst0", 4'b0000, 4'b0000, 4'b0000);
        tick_chk("t5_inrst1", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick_chk($sformatf("t5_rewait%0d", k), 4'b0000, 4'b0000, 4'b0000);
        tick_chk("t5_repress", 4'b0001, 4'b0001, 4'b0000);
        sw = 4'b0000;
        for (int k = 0; k < 5; k++) tick_chk($sformatf("t5_hold_b%0d", k), 4'b0001, 4'b0000, 4'b0000);
        tick_chk("t5_release", 4'b0000, 4'b0000, 4'b0001);

        // 6. No auto-repeat instance: single press over a long hold
        sw_nr = 4'b0001;
        for (int k = 0; k < 5; k++) tick_nr($sformatf("t6_wait%0d", k), 4'b0000, 4'b0000, 4'b0000);
        tick_nr("t6_accept", 4'b0001, 4'b0001, 4'b0000);
        for (int k = 1; k <= 50; k++) tick_nr($sformatf("t6_hold%0d", k), 4'b0001, 4'b0000, 4'b0000);
        sw_nr = 4'b0000;
        for (int k = 0; k < 5; k++) tick_nr($sformatf("t6_fall%0d", k), 4'b0001, 4'b0000, 4'b0000);
        tick_nr("t6_release", 4'b0000, 4'b0000, 4'b0001);
        check("t6_main_idle", {20'd0, lvl, pr, rl}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
